fwd_scoreboard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the ARM pipeline, successor to the fixed two-stage forwarding logic.

---
 rtl/fwd_scoreboard_unit.sv | 130 +++++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit
//   Forwarding and load-use hazard unit for the ARM pipeline. Tracks in-flight
//   writebacks for DEPTH stages after ID (stage 1 = EXE) in a shift-register
//   scoreboard and resolves each ID source operand to the youngest writer.
//   Load results are forwardable only from stage LOAD_RDY on, so a younger
//   load match stalls ID until the load has drained far enough. A
//   saturating counter accumulates the number of stall cycles.
//
//   Build option FWD_SCOREBOARD_FORWARD_EN:
//     defined   - forwarding selects active, only young loads stall.
//     undefined - selects tied to 0, any pending writer of a source stalls
//                 (classic no-forwarding interlock). Scoreboard and counter
//                 behave identically in both builds.
//
// Ports
//   clk_i            clock, rising edge
//   rst_n_i          synchronous active-low reset
//   advance_i        pipeline moves ID->EXE this cycle (0 = global freeze)
//   flush_i          kill the instruction in ID
//   id_valid_i       ID holds a real instruction
//   id_wb_en_i       ID instruction writes a register
//   id_mem_rd_i      ID instruction is a load
//   id_dst_i         ID destination register
//   id_src_i         packed sources, src i = [i*REG_AW +: REG_AW]
//   id_src_used_i    bit i = src i is actually read
//   sel_src_o        per-source select, 0 = register file, k = stage k
//   hazard_stall_o   hold PC/IF/ID and insert a bubble
//   stall_cnt_o      saturating count of stall cycles
module fwd_scoreboard_unit #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 3,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       advance_i,
  input  logic                       flush_i,
  input  logic                       id_valid_i,
  input  logic                       id_wb_en_i,
  input  logic                       id_mem_rd_i,
  input  logic [REG_AW-1:0]          id_dst_i,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src_i,
  input  logic [NUM_SRC-1:0]         id_src_used_i,
  output logic [NUM_SRC*SEL_W-1:0]   sel_src_o,
  output logic                       hazard_stall_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  logic              vld_q [1:DEPTH];
  logic              wb_q  [1:DEPTH];
  logic              ld_q  [1:DEPTH];
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic [SEL_W-1:0]  sel_i;
  logic              ld_i;
  logic              stall_hit;

  always_comb begin
    sel_src_o = '0;
    stall_hit = 1'b0;
    sel_i     = '0;
    ld_i      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_i = '0;
      ld_i  = 1'b0;
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_src_used_i[i] && vld_q[k] && wb_q[k] &&
            (dst_q[k] == id_src_i[i*REG_AW +: REG_AW])) begin
          sel_i = SEL_W'(k);
          ld_i  = ld_q[k];
        end
      end
`ifdef FWD_SCOREBOARD_FORWARD_EN
      if (id_valid_i) sel_src_o[i*SEL_W +: SEL_W] = sel_i;
      if (ld_i && (int'(sel_i) < LOAD_RDY)) stall_hit = 1'b1;
`else
      // ld_i is only ever set alongside a hit, so this is simply "any hit".
      if ((sel_i != '0) || ld_i) stall_hit = 1'b1;
`endif
    end
  end

  assign hazard_stall_o = id_valid_i & ~flush_i & stall_hit;

  assign stall_cnt_d = (hazard_stall_o && (stall_cnt_q != '1)) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 1; k <= DEPTH; k++) begin
        vld_q[k] <= 1'b0;
        wb_q[k]  <= 1'b0;
        ld_q[k]  <= 1'b0;
        dst_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      if (advance_i) begin
        for (int k = 2; k <= DEPTH; k++) begin
          vld_q[k] <= vld_q[k-1];
          wb_q[k]  <= wb_q[k-1];
          ld_q[k]  <= ld_q[k-1];
          dst_q[k] <= dst_q[k-1];
        end
        // Flushed or stalled ID instruction enters EXE as a bubble.
        if (id_valid_i && !flush_i && !hazard_stall_o) begin
          vld_q[1] <= 1'b1;
          wb_q[1]  <= id_wb_en_i;
          ld_q[1]  <= id_mem_rd_i;
          dst_q[1] <= id_dst_i;
        end else begin
          vld_q[1] <= 1'b0;
          wb_q[1]  <= 1'b0;
          ld_q[1]  <= 1'b0;
          dst_q[1] <= '0;
        end
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
module tb_fwd_scoreboard_unit;

  localparam int LOAD_RDY = 3;

  logic       clk = 1'b0;
  logic       rst_n, advance, flush, id_valid, id_wb_en, id_mem_rd;
  logic [3:0] id_dst;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] sel_src, sel_src_s;
  logic       hazard_stall, hazard_stall_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  fwd_scoreboard_unit #(.LOAD_RDY(LOAD_RDY)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .advance_i(advance), .flush_i(flush),
    .id_valid_i(id_valid), .id_wb_en_i(id_wb_en), .id_mem_rd_i(id_mem_rd),
    .id_dst_i(id_dst), .id_src_i(id_src), .id_src_used_i(id_src_used),
    .sel_src_o(sel_src), .hazard_stall_o(hazard_stall), .stall_cnt_o(stall_cnt));

  fwd_scoreboard_unit #(.LOAD_RDY(LOAD_RDY), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .advance_i(advance), .flush_i(flush),
    .id_valid_i(id_valid), .id_wb_en_i(id_wb_en), .id_mem_rd_i(id_mem_rd),
    .id_dst_i(id_dst), .id_src_i(id_src), .id_src_used_i(id_src_used),
    .sel_src_o(sel_src_s), .hazard_stall_o(hazard_stall_s), .stall_cnt_o(stall_cnt_s));

  int n_chk = 0;
  int n_fail = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // Reference scoreboard, stage 1..3
  logic       m_vld [1:3];
  logic       m_wb  [1:3];
  logic       m_ld  [1:3];
  logic [3:0] m_dst [1:3];
  int         m_cnt;

  typedef struct {
    logic [3:0] sel;
    logic       stall;
    int         cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0] o_sel;
  logic       o_stall;
  logic [15:0] o_cnt;

  function automatic void model_clear();
    for (int k = 1; k <= 3; k++) begin
      m_vld[k] = 0; m_wb[k] = 0; m_ld[k] = 0; m_dst[k] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_eval(output logic [3:0] sel, output logic stall);
    logic st;
    logic [3:0] src;
    int found;
    sel = 0;
    st = 0;
    for (int i = 0; i < 2; i++) begin
      src = (i == 0) ? id_src[3:0] : id_src[7:4];
      found = 0;
      for (int k = 1; k <= 3; k++)
        if (found == 0 && id_src_used[i] && m_vld[k] && m_wb[k] && m_dst[k] == src)
          found = k;
`ifdef FWD_SCOREBOARD_FORWARD_EN
      if (id_valid) sel[i*2 +: 2] = 2'(found);
      if (found != 0 && m_ld[found] && found < LOAD_RDY) st = 1;
`else
      if (found != 0) st = 1;
`endif
    end
    stall = id_valid & ~flush & st;
  endfunction

  function automatic void model_step(input logic stall);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (advance) begin
        for (int k = 3; k >= 2; k--) begin
          m_vld[k] = m_vld[k-1]; m_wb[k] = m_wb[k-1];
          m_ld[k] = m_ld[k-1]; m_dst[k] = m_dst[k-1];
        end
        if (id_valid && !flush && !stall) begin
          m_vld[1] = 1; m_wb[1] = id_wb_en; m_ld[1] = id_mem_rd; m_dst[1] = id_dst;
        end else begin
          m_vld[1] = 0; m_wb[1] = 0; m_ld[1] = 0; m_dst[1] = 0;
        end
      end
      if (stall && m_cnt < 65535) m_cnt++;
    end
  endfunction

  task automatic set_id(input logic v, input logic wb, input logic ld, input logic [3:0] dst,
                        input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used);
    id_valid = v; id_wb_en = wb; id_mem_rd = ld; id_dst = dst;
    id_src = {s1, s0}; id_src_used = used;
  endtask

  // One clock: push expectation, sample at negedge, compare, advance model.
  task automatic cyc();
    exp_t e;
    logic [3:0] es;
    logic est;
    model_eval(es, est);
    e.sel = es; e.stall = est; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    o_sel = sel_src; o_stall = hazard_stall; o_cnt = stall_cnt;
    e = exp_q.pop_front();
    chk("sel", 32'(o_sel), 32'(e.sel));
    chk("stall", 32'(o_stall), 32'(e.stall));
    chk("cnt", 32'(o_cnt), 32'(e.cnt));
    chk("cnt_sat", 32'(stall_cnt_s), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
    model_step(est);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; advance = 1; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1;
  endtask

  initial begin
    model_clear();
    // reset with random inputs
    rst_n = 0; advance = 1'($urandom); flush = 1'($urandom);
    set_id(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 2'($urandom));
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    for (int n = 0; n < 2; n++) begin
      advance = 1'($urandom); flush = 1'($urandom);
      set_id(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 2'($urandom));
      cyc();
      chk("sel0", 32'(o_sel), 32'd0);
      chk("stall0", 32'(o_stall), 32'd0);
      chk("cnt0", 32'(o_cnt), 32'd0);
    end
    rst_n = 1;

    phase = "add_fwd";
    do_reset();
    set_id(1, 1, 0, 3, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 5, 3, 0, 2'b01); cyc();
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("sel_k1", 32'(o_sel[1:0]), 32'd1);
    chk("nostall_k1", 32'(o_stall), 32'd0);
`else
    chk("stall_k1", 32'(o_stall), 32'd1);
`endif
    set_id(1, 1, 0, 6, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 7, 1, 3, 2'b10); cyc();
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("sel_k3", 32'(o_sel), 32'b1100);
`else
    chk("stall_k3", 32'(o_stall), 32'd1);
    chk("sel_off", 32'(o_sel), 32'd0);
`endif

    phase = "youngest";
    do_reset();
    set_id(1, 1, 0, 3, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 3, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 8, 3, 3, 2'b11); cyc();
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("sel_young", 32'(o_sel), 32'b0101);
`else
    chk("stall_young", 32'(o_stall), 32'd1);
`endif

    phase = "load_use";
    do_reset();
    set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 7, 2, 0, 2'b01);
    cyc(); chk("st_c1", 32'(o_stall), 32'd1);
    cyc(); chk("st_c2", 32'(o_stall), 32'd1);
    cyc();
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("st_c3", 32'(o_stall), 32'd0);
    chk("sel_c3", 32'(o_sel[1:0]), 32'd3);
    chk("cnt_c3", 32'(o_cnt), 32'd2);
`else
    chk("st_c3", 32'(o_stall), 32'd1);
    cyc();
    chk("st_c4", 32'(o_stall), 32'd0);
    chk("cnt_c4", 32'(o_cnt), 32'd3);
`endif

    phase = "load_freeze";
    do_reset();
    set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 7, 2, 0, 2'b01); cyc();
    advance = 0;
    for (int n = 0; n < 3; n++) begin
      cyc(); chk("st_frz", 32'(o_stall), 32'd1);
    end
    advance = 1;
    cyc(); chk("st_rel", 32'(o_stall), 32'd1);
    cyc();
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("st_done", 32'(o_stall), 32'd0);
    chk("sel_done", 32'(o_sel[1:0]), 32'd3);
    chk("cnt_done", 32'(o_cnt), 32'd5);
`else
    chk("st_k3", 32'(o_stall), 32'd1);
    cyc();
    chk("st_done", 32'(o_stall), 32'd0);
    chk("cnt_done", 32'(o_cnt), 32'd6);
`endif
    chk("cnt_sat3", 32'(stall_cnt_s), 32'd3);

    phase = "load_flush";
    do_reset();
    set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 7, 2, 0, 2'b01); flush = 1;
    cyc(); chk("st_flush", 32'(o_stall), 32'd0);
    flush = 0;
    cyc(); chk("st_after", 32'(o_stall), 32'd1);
`ifdef FWD_SCOREBOARD_FORWARD_EN
    chk("sel_after", 32'(o_sel[1:0]), 32'd2);
`endif

    phase = "reset_mid";
    do_reset();
    set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
    set_id(1, 1, 0, 7, 0, 2, 2'b10);
    cyc(); chk("st_pre", 32'(o_stall), 32'd1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
    chk("st_post", 32'(o_stall), 32'd0);
    chk("sel_post", 32'(o_sel), 32'd0);
    chk("cnt_post", 32'(o_cnt), 32'd0);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      advance = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 2'($urandom));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
